// File: rtl/instruction_sequencer.sv
// Streams a zero-terminated program from on-chip memory to a CPU ready/valid handshake.
// Optional result checker is compiled in when SEQUENCER_CHECKER_EN is defined.

module instruction_sequencer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PROGRAM_DEPTH     = 1024,
    parameter int MAX_ISSUE         = 60,
    parameter int DATA_WIDTH        = 8
) (
    input  logic                                 clock_in,
    input  logic                                 reset_n_in,
    input  logic                                 start_in,
    input  logic                                 program_write_enable_in,
    input  logic [$clog2(PROGRAM_DEPTH)-1:0]     program_write_address_in,
    input  logic [INSTRUCTION_WIDTH-1:0]         program_write_data_in,
    input  logic                                 cpu_ready_in,
    output logic [INSTRUCTION_WIDTH-1:0]         current_instruction_out,
    output logic                                 instruction_valid_out,
    output logic [$clog2(MAX_ISSUE+1)-1:0]       issue_count_out,
    output logic                                 busy_out,
    output logic                                 done_out
`ifdef SEQUENCER_CHECKER_EN
    ,
    input  logic                                 expected_write_enable_in,
    input  logic [DATA_WIDTH:0]                  expected_write_data_in,
    input  logic [DATA_WIDTH-1:0]                check_value_in,
    output logic [$clog2(MAX_ISSUE+1)-1:0]       pass_count_out,
    output logic [$clog2(MAX_ISSUE+1)-1:0]       fail_count_out
`endif
);

    localparam int AW = $clog2(PROGRAM_DEPTH);
    localparam int CW = $clog2(MAX_ISSUE + 1);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(PROGRAM_DEPTH - 1);
    localparam logic [CW-1:0] ISSUE_LIMIT = CW'(MAX_ISSUE);

    if (PROGRAM_DEPTH < 2 || MAX_ISSUE < 1 || DATA_WIDTH < 1 || INSTRUCTION_WIDTH < 1) begin : g_param_check
        $error("instruction_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [AW-1:0]                addr_q, addr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [INSTRUCTION_WIDTH-1:0] fetched_q;
    logic [INSTRUCTION_WIDTH-1:0] program_mem [PROGRAM_DEPTH];
    logic                         program_window;

    // The program may only change while no run is reading it.
    assign program_window = (state_q == IDLE) || (state_q == DONE);

    // NOTE: memory array and its read register carry no reset so they map onto block RAM;
    // the program survives a reset and the read register is never observed outside ISSUE.
    always_ff @(posedge clock_in) begin
        if (program_write_enable_in && program_window) begin
            program_mem[program_write_address_in] <= program_write_data_in;
        end
        if (state_q == FETCH) begin
            fetched_q <= program_mem[addr_q];
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_in) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                if (fetched_q == '0) begin
                    state_d = DONE;
                end else if (cpu_ready_in) begin
                    count_d = count_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    if ((count_d == ISSUE_LIMIT) || (addr_q == LAST_ADDR)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FETCH) || (state_d == ISSUE);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction_valid_out   = (state_q == ISSUE) && (fetched_q != '0);
    assign current_instruction_out = instruction_valid_out ? fetched_q : '0;
    assign issue_count_out         = count_q;
    assign busy_out                = busy_q;
    assign done_out                = done_q;

`ifdef SEQUENCER_CHECKER_EN
    logic                  accept;
    logic                  run_start;
    logic [DATA_WIDTH:0]   expected_mem [PROGRAM_DEPTH];
    logic [DATA_WIDTH:0]   expected_entry_q;
    logic                  check_pending_q, check_pending_d;
    logic [CW-1:0]         pass_q, pass_d;
    logic [CW-1:0]         fail_q, fail_d;

    assign accept    = instruction_valid_out && cpu_ready_in;
    assign run_start = program_window && start_in;

    // The expected entry is read on acceptance so it lines up with the next-cycle sample.
    always_ff @(posedge clock_in) begin
        if (expected_write_enable_in && program_window) begin
            expected_mem[program_write_address_in] <= expected_write_data_in;
        end
        if (accept) begin
            expected_entry_q <= expected_mem[addr_q];
        end
    end

    always_comb begin
        check_pending_d = accept;
        pass_d          = pass_q;
        fail_d          = fail_q;
        if (run_start) begin
            pass_d = '0;
            fail_d = '0;
        end else if (check_pending_q && expected_entry_q[DATA_WIDTH]) begin
            if (check_value_in == expected_entry_q[DATA_WIDTH-1:0]) begin
                if (pass_q != '1) pass_d = pass_q + 1'b1;
            end else begin
                if (fail_q != '1) fail_d = fail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            check_pending_q <= 1'b0;
            pass_q          <= '0;
            fail_q          <= '0;
        end else begin
            check_pending_q <= check_pending_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
        end
    end

    assign pass_count_out = pass_q;
    assign fail_count_out = fail_q;
`endif

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL have parameter INSTRUCTION_WIDTH, default 32: width of one instruction word.
REQ-002 The block SHALL have parameter PROGRAM_DEPTH, default 1024: number of program memory entries.
REQ-003 The block SHALL have parameter MAX_ISSUE, default 60: issue limit per run.
REQ-004 The block SHALL have parameter DATA_WIDTH, default 8: register value width used by the checker.
REQ-005 The block SHALL have port clock_in, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset_n_in, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port start_in, input, 1 bit: level; a run begins from IDLE or DONE when it is high.
REQ-008 The block SHALL have port program_write_enable_in, input, 1 bit: program memory write strobe.
REQ-009 The block SHALL have port program_write_address_in, input, $clog2(PROGRAM_DEPTH) bits: program write address.
REQ-010 The block SHALL have port program_write_data_in, input, INSTRUCTION_WIDTH bits: program write data.
REQ-011 The block SHALL have port cpu_ready_in, input, 1 bit: CPU accepts the presented instruction this cycle.
REQ-012 The block SHALL have port current_instruction_out, output, INSTRUCTION_WIDTH bits: instruction presented to the CPU.
REQ-013 The block SHALL have port instruction_valid_out, output, 1 bit: current_instruction_out is valid.
REQ-014 The block SHALL have port issue_count_out, output, $clog2(MAX_ISSUE+1) bits: instructions accepted this run.
REQ-015 The block SHALL have port busy_out, output, 1 bit: a run is in progress.
REQ-016 The block SHALL have port done_out, output, 1 bit: the last run has completed.

Function
REQ-017 The block SHALL implement the states IDLE, FETCH, ISSUE and DONE.
REQ-018 IDLE/DONE with start_in=1 SHALL go to FETCH with read address 0 and issue_count_out cleared.
REQ-019 Program memory read SHALL be synchronous: the FETCH-cycle read lands in ISSUE on the next cycle.
REQ-020 ISSUE with a non-zero fetched word SHALL drive current_instruction_out=word and instruction_valid_out=1.
REQ-021 The presented instruction SHALL be held stable until cpu_ready_in=1.
REQ-022 An accepted instruction (valid and ready) SHALL increment issue_count_out and the address by 1.
REQ-023 After an accepted instruction the block SHALL go to FETCH, or to DONE if the count reaches MAX_ISSUE or the address wraps past PROGRAM_DEPTH-1.
REQ-024 A fetched all-zero word SHALL end the run: go to DONE without issuing it and without incrementing the count.
REQ-025 Whenever instruction_valid_out=0, current_instruction_out SHALL be all zero.
REQ-026 Throughput with cpu_ready_in held high SHALL be one instruction every 2 cycles (FETCH then ISSUE).
REQ-027 busy_out SHALL be 1 in FETCH and ISSUE.
REQ-028 done_out SHALL be 1 only in DONE and SHALL clear on the cycle the block leaves DONE.
REQ-029 Program writes SHALL take effect only in IDLE or DONE; writes in FETCH/ISSUE SHALL be ignored.
REQ-030 A simultaneous start_in=1 and program write in IDLE SHALL commit the write, and the run SHALL start; the first fetch SHALL see the new data if the write targets address 0.
REQ-031 start_in held high in DONE SHALL immediately restart a run.

Reset
REQ-032 reset_n_in=0 sampled at a clock_in rising edge SHALL force IDLE with every output zero: instruction_valid_out, current_instruction_out, issue_count_out, busy_out and done_out.
REQ-033 Reset mid-run SHALL abort the run at once with no further issue; program memory contents SHALL be preserved.

Configuration
REQ-034 With SEQUENCER_CHECKER_EN defined, the block SHALL add these ports: expected_write_enable_in; expected_write_data_in (DATA_WIDTH+1 bits, MSB = check flag, written at program_write_address_in); check_value_in (DATA_WIDTH); pass_count_out; fail_count_out (each $clog2(MAX_ISSUE+1)).
REQ-035 With the checker enabled, check_value_in SHALL be sampled the cycle after each acceptance and compared against the expected entry for that index when its flag is set; a match SHALL increment pass_count_out, otherwise fail_count_out.
REQ-036 Both checker counters SHALL clear on reset and on run start, and SHALL saturate.
REQ-037 Without SEQUENCER_CHECKER_EN, the checker ports, memory and counters SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-038 Load 3 words then a zero word, pulse start_in, hold cpu_ready_in=1 -> exactly 3 issues on alternate cycles, issue_count_out=3, done_out=1, and the zero word is never presented.
REQ-039 Hold cpu_ready_in=0 for 5 cycles during ISSUE -> instruction stable for 5 cycles, count unchanged, and 1 accept on release.
REQ-040 Fill 100 non-zero words with MAX_ISSUE=60 -> DONE after 60 issues, issue_count_out=60.
REQ-041 Assert reset_n_in=0 after the 2nd issue -> all outputs 0 next cycle, then a restart reissues from address 0.
REQ-042 Write to address 1 during ISSUE -> memory unchanged and the original word at address 1 is issued.
REQ-043 With checker enabled: expected {1,5}, {1,15}, {0,x}, and check_value_in of 5, 14, 0 -> pass_count_out=1, fail_count_out=1.
